// File: rtl/rv32_pkg.sv
// Shared RV32I decode constants, ALU opsel encodings and the issue-stage decoder.
// The ALU_OP_* values are the ALU's own opsel map and must stay in lock-step with it.
package rv32_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [3:0] ALU_OP_ADD   = 4'd0;
    localparam logic [3:0] ALU_OP_SUB   = 4'd1;
    localparam logic [3:0] ALU_OP_AND   = 4'd2;
    localparam logic [3:0] ALU_OP_OR    = 4'd3;
    localparam logic [3:0] ALU_OP_XOR   = 4'd4;
    localparam logic [3:0] ALU_OP_SLT   = 4'd5;
    localparam logic [3:0] ALU_OP_SLTU  = 4'd6;
    localparam logic [3:0] ALU_OP_ADDI  = 4'd7;
    localparam logic [3:0] ALU_OP_ANDI  = 4'd9;
    localparam logic [3:0] ALU_OP_ORI   = 4'd10;
    localparam logic [3:0] ALU_OP_XORI  = 4'd11;
    localparam logic [3:0] ALU_OP_SLTI  = 4'd12;
    localparam logic [3:0] ALU_OP_SLTIU = 4'd13;
    localparam logic [3:0] ALU_OP_LUI   = 4'd14;
    localparam logic [3:0] ALU_OP_AUIPC = 4'd15;

    typedef struct packed {
        logic       legal;
        logic [3:0] opsel;
        logic       use_rs1;
        logic       use_rs2;
    } dec_t;

    // Register-use flags are only raised for legal instructions so garbage never stalls.
    function automatic dec_t decode(input logic [31:0] instr);
        dec_t       d;
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = instr[14:12];
        f7 = instr[31:25];
        d  = '0;
        case (instr[6:0])
            OPC_OP: begin
                if (f7 == F7_BASE) begin
                    d.legal = 1'b1;
                    case (f3)
                        F3_ADD:  d.opsel = ALU_OP_ADD;
                        F3_AND:  d.opsel = ALU_OP_AND;
                        F3_OR:   d.opsel = ALU_OP_OR;
                        F3_XOR:  d.opsel = ALU_OP_XOR;
                        F3_SLT:  d.opsel = ALU_OP_SLT;
                        F3_SLTU: d.opsel = ALU_OP_SLTU;
                        default: d.legal = 1'b0;
                    endcase
                end else if (f7 == F7_ALT && f3 == F3_ADD) begin
                    d.legal = 1'b1;
                    d.opsel = ALU_OP_SUB;
                end
                d.use_rs1 = d.legal;
                d.use_rs2 = d.legal;
            end
            OPC_OPIMM: begin
                d.legal = 1'b1;
                case (f3)
                    F3_ADD:  d.opsel = ALU_OP_ADDI;
                    F3_AND:  d.opsel = ALU_OP_ANDI;
                    F3_OR:   d.opsel = ALU_OP_ORI;
                    F3_XOR:  d.opsel = ALU_OP_XORI;
                    F3_SLT:  d.opsel = ALU_OP_SLTI;
                    F3_SLTU: d.opsel = ALU_OP_SLTIU;
                    default: d.legal = 1'b0;
                endcase
                d.use_rs1 = d.legal;
            end
            OPC_LUI: begin
                d.legal = 1'b1;
                d.opsel = ALU_OP_LUI;
            end
            OPC_AUIPC: begin
                d.legal = 1'b1;
                d.opsel = ALU_OP_AUIPC;
            end
            default: d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/rv32_regfile.sv
// Architectural register file: two async read ports, one sync write port, x0 reads zero.
// A write and a read of the same register in one cycle return the value being written.
module rv32_regfile #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_we,
    input  logic [4:0]      i_waddr,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [4:0]      i_raddr1,
    input  logic [4:0]      i_raddr2,
    output logic [XLEN-1:0] o_rdata1,
    output logic [XLEN-1:0] o_rdata2
);

    logic [XLEN-1:0] r_mem [NREG];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
        end else if (i_we && i_waddr != 5'd0) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata1 = (i_raddr1 == 5'd0) ? '0 :
                      (i_we && i_waddr == i_raddr1) ? i_wdata : r_mem[i_raddr1];
    assign o_rdata2 = (i_raddr2 == 5'd0) ? '0 :
                      (i_we && i_waddr == i_raddr2) ? i_wdata : r_mem[i_raddr2];

endmodule

// File: rtl/rv32_alu_issue.sv
// Decode/issue stage in front of the RV32 ALU: decodes, reads operands, issues a registered
// bundle and writes the ALU's registered result back two cycles after acceptance.
module rv32_alu_issue #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int BYPASS = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] instr_pc,
    output logic            alu_enable,
    output logic [3:0]      alu_opsel,
    output logic [XLEN-1:0] alu_s1,
    output logic [XLEN-1:0] alu_s2,
    output logic [31:0]     alu_code_bus,
    output logic [XLEN-1:0] alu_pc,
    input  logic [XLEN-1:0] alu_result,
    output logic            illegal_instr,
    output logic            wb_valid,
    output logic [4:0]      wb_rd
);
    import rv32_pkg::*;

    dec_t            w_dec;
    logic [4:0]      w_rs1, w_rs2;
    logic [XLEN-1:0] w_rdata1, w_rdata2;
    logic            w_we, w_haz_d, w_haz_w, w_stall, w_xfer, w_issue;

    logic            r_rdy, r_vld_p1, r_ill_p1, r_vld_p2;
    logic [4:0]      r_rd_p1, r_rd_p2;
    logic [3:0]      r_op_p1;
    logic [XLEN-1:0] r_s1_p1, r_s2_p1, r_pc_p1;
    logic [31:0]     r_code_p1;

    function automatic logic hit(input logic use_rs, input logic [4:0] rs,
                                 input logic vld, input logic [4:0] rd);
        return use_rs && vld && (rd != 5'd0) && (rd == rs);
    endfunction

    assign w_dec = decode(instr);
    assign w_rs1 = instr[19:15];
    assign w_rs2 = instr[24:20];

    assign w_haz_d = hit(w_dec.use_rs1, w_rs1, r_vld_p1, r_rd_p1) |
                     hit(w_dec.use_rs2, w_rs2, r_vld_p1, r_rd_p1);
    assign w_haz_w = hit(w_dec.use_rs1, w_rs1, r_vld_p2, r_rd_p2) |
                     hit(w_dec.use_rs2, w_rs2, r_vld_p2, r_rd_p2);
    // W-stage forwarding comes from the regfile's write-through path; without BYPASS we wait it out.
    assign w_stall = (BYPASS == 0) ? (w_haz_d | w_haz_w) : w_haz_d;

    assign instr_ready = r_rdy & ~w_stall;
    assign w_xfer      = instr_valid & instr_ready;
    assign w_issue     = w_xfer & w_dec.legal;
    assign w_we        = r_vld_p2 & (r_rd_p2 != 5'd0);

    rv32_regfile #(.XLEN(XLEN), .NREG(NREG)) u_rf (
        .clk      (clk),
        .rst      (rst),
        .i_we     (w_we),
        .i_waddr  (r_rd_p2),
        .i_wdata  (alu_result),
        .i_raddr1 (w_rs1),
        .i_raddr2 (w_rs2),
        .o_rdata1 (w_rdata1),
        .o_rdata2 (w_rdata2)
    );

    // p1: issue (D) stage, p2: write-back (W) stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdy    <= 1'b0;
            r_vld_p1 <= 1'b0;
            r_ill_p1 <= 1'b0;
            r_rd_p1  <= '0;
            r_vld_p2 <= 1'b0;
            r_rd_p2  <= '0;
        end else begin
            r_rdy    <= 1'b1;
            r_vld_p1 <= w_issue;
            r_ill_p1 <= w_xfer & ~w_dec.legal;
            if (w_issue) r_rd_p1 <= instr[11:7];
            r_vld_p2 <= r_vld_p1;
            r_rd_p2  <= r_rd_p1;
        end
    end

    // Bundle holds its last value between issues; the ALU only looks at it under enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op_p1   <= '0;
            r_s1_p1   <= '0;
            r_s2_p1   <= '0;
            r_code_p1 <= '0;
            r_pc_p1   <= '0;
        end else if (w_issue) begin
            r_op_p1   <= w_dec.opsel;
            r_s1_p1   <= w_dec.use_rs1 ? w_rdata1 : '0;
            r_s2_p1   <= w_dec.use_rs2 ? w_rdata2 : '0;
            r_code_p1 <= instr;
            r_pc_p1   <= instr_pc;
        end
    end

    assign alu_enable    = r_vld_p1;
    assign alu_opsel     = r_op_p1;
    assign alu_s1        = r_s1_p1;
    assign alu_s2        = r_s2_p1;
    assign alu_code_bus  = r_code_p1;
    assign alu_pc        = r_pc_p1;
    assign illegal_instr = r_ill_p1;
    assign wb_valid      = w_we;
    assign wb_rd         = r_rd_p2;

endmodule
